// File: rtl/vr_log_hdr_ring_pkg.sv
// Shared types and defaults for the VR log-entry header ring.
// Latency: n/a (types, constants only).
// Backpressure: n/a.
package vr_log_hdr_ring_pkg;

  localparam int LOG_HDR_DEPTH   = 2048;
  localparam int LOG_ENTRY_HDR_W = 128;
  localparam int INT_W           = 64;
  localparam int LOG_HDR_PTR_W   = $clog2(LOG_HDR_DEPTH);

  // Snapshot of the ring bounds at the default geometry.
  typedef struct packed {
    logic [INT_W-1:0]       first_op;
    logic [INT_W-1:0]       last_op;
    logic [INT_W-1:0]       last_commit;
    logic [LOG_HDR_PTR_W:0] head;
    logic [LOG_HDR_PTR_W:0] tail;
    logic                   empty;
    logic                   full;
  } vr_log_ring_status_t;

  // Reasons a request is rejected with an err_seq pulse.
  typedef enum logic [0:0] {
    SEQ_GAP,
    TRUNC_COMMITTED
  } vr_log_err_e;

endpackage

// File: rtl/vr_log_hdr_mem.sv
// 1R1W header storage, DEPTH x ENTRY_W.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: none; rd_data holds its value while rd_en is low.
module vr_log_hdr_mem
  import vr_log_hdr_ring_pkg::*;
#(
  parameter int DEPTH   = LOG_HDR_DEPTH,
  parameter int ENTRY_W = LOG_ENTRY_HDR_W,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write port plus registered read; a same-slot read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vr_log_hdr_ring.sv
// Circular log of VR entry headers: append, op-indexed read, commit, clean, truncate.
// Latency: state updates next edge; read response one cycle after accept.
// Backpressure: append_rdy low when full or trunc/clean active; reads stall on rd_resp_rdy.
// Optional: define BEEHIVE_VR_LOG_AUTO_EVICT_EN to let appends evict a committed head when full.
module vr_log_hdr_ring
  import vr_log_hdr_ring_pkg::*;
#(
  parameter int DEPTH   = LOG_HDR_DEPTH,
  parameter int ENTRY_W = LOG_ENTRY_HDR_W,
  parameter int OP_W    = INT_W,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               append_val,
  input  logic [OP_W-1:0]    append_op,
  input  logic [ENTRY_W-1:0] append_entry,
  output logic               append_rdy,
  input  logic               clean_val,
  input  logic [OP_W-1:0]    clean_up_to,
  input  logic               trunc_val,
  input  logic [OP_W-1:0]    trunc_op,
  input  logic               commit_val,
  input  logic [OP_W-1:0]    commit_op,
  input  logic               rd_req_val,
  input  logic [OP_W-1:0]    rd_req_op,
  output logic               rd_req_rdy,
  output logic               rd_resp_val,
  output logic               rd_resp_hit,
  output logic               rd_resp_committed,
  output logic [ENTRY_W-1:0] rd_resp_entry,
  input  logic               rd_resp_rdy,
  output logic [OP_W-1:0]    first_op,
  output logic [OP_W-1:0]    last_op,
  output logic [OP_W-1:0]    last_commit,
  output logic [PTR_W:0]     head,
  output logic [PTR_W:0]     tail,
  output logic               empty,
  output logic               full,
  output logic               err_seq
);

  localparam int PW1 = PTR_W + 1;

  logic [PTR_W:0]     count;
  logic [OP_W-1:0]    count_op;
  logic [PTR_W:0]     head_nx, tail_nx;
  logic [OP_W-1:0]    first_nx, last_nx, commit_nx;
  logic               err_nx;
  logic               wr_en;
  logic [OP_W-1:0]    clean_n, committed_cnt, trunc_drop, commit_cand;
  logic [OP_W-1:0]    rd_off;
  logic               rd_hit, rd_fire;
  logic [PTR_W-1:0]   rd_addr;
  logic [ENTRY_W-1:0] mem_rd_data;

  assign count    = tail - head;
  assign count_op = {{(OP_W-PW1){1'b0}}, count};
  assign empty    = (head == tail);
  assign full     = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);

`ifdef BEEHIVE_VR_LOG_AUTO_EVICT_EN
  assign append_rdy = !trunc_val && !clean_val && (!full || (first_op <= last_commit));
`else
  assign append_rdy = !trunc_val && !clean_val && !full;
`endif

  // Next-state for bounds and pointers: trunc beats clean beats append; commit sees the result.
  always_comb begin
    head_nx       = head;
    tail_nx       = tail;
    first_nx      = first_op;
    last_nx       = last_op;
    commit_nx     = last_commit;
    err_nx        = 1'b0;
    wr_en         = 1'b0;
    clean_n       = '0;
    committed_cnt = '0;
    trunc_drop    = last_op - trunc_op;
    commit_cand   = '0;
    if (trunc_val) begin
      if (trunc_op < last_commit) begin
        err_nx = 1'b1;
      end else if (trunc_op < last_op) begin
        if (empty || (trunc_op < first_op)) tail_nx = head;
        else                                tail_nx = tail - trunc_drop[PTR_W:0];
        last_nx = trunc_op;
      end
    end else if (clean_val) begin
      // Only committed entries may leave the low end.
      if (!empty && (clean_up_to > first_op) && (last_commit >= first_op)) begin
        committed_cnt = last_commit - first_op + OP_W'(1);
        clean_n       = clean_up_to - first_op;
        if (count_op < clean_n)      clean_n = count_op;
        if (committed_cnt < clean_n) clean_n = committed_cnt;
        head_nx  = head + clean_n[PTR_W:0];
        first_nx = first_op + clean_n;
      end
    end else if (append_val && append_rdy) begin
      if (empty || (append_op == last_op + OP_W'(1))) begin
        wr_en   = 1'b1;
        tail_nx = tail + PW1'(1);
        last_nx = append_op;
        if (empty) first_nx = append_op;
`ifdef BEEHIVE_VR_LOG_AUTO_EVICT_EN
        if (full) begin
          head_nx  = head + PW1'(1);
          first_nx = first_op + OP_W'(1);
        end
`endif
      end else begin
        err_nx = 1'b1;
      end
    end
    commit_cand = (commit_op < last_nx) ? commit_op : last_nx;
    if (commit_val && (commit_cand > last_commit)) commit_nx = commit_cand;
  end

  // Ring bounds, commit point and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      first_op    <= '0;
      last_op     <= '0;
      last_commit <= '0;
      err_seq     <= 1'b0;
    end else begin
      head        <= head_nx;
      tail        <= tail_nx;
      first_op    <= first_nx;
      last_op     <= last_nx;
      last_commit <= commit_nx;
      err_seq     <= err_nx;
    end
  end

  // Read lookup against the bounds as they stand in the accept cycle.
  assign rd_req_rdy = !rd_resp_val || rd_resp_rdy;
  assign rd_fire    = rd_req_val && rd_req_rdy;
  assign rd_off     = rd_req_op - first_op;
  assign rd_hit     = !empty && (rd_off <= (last_op - first_op));
  assign rd_addr    = head[PTR_W-1:0] + rd_off[PTR_W-1:0];

  // Response register: loads on accept, holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_resp_val       <= 1'b0;
      rd_resp_hit       <= 1'b0;
      rd_resp_committed <= 1'b0;
    end else if (rd_fire) begin
      rd_resp_val       <= 1'b1;
      rd_resp_hit       <= rd_hit;
      rd_resp_committed <= (rd_req_op <= last_commit);
    end else if (rd_resp_rdy) begin
      rd_resp_val <= 1'b0;
    end
  end

  assign rd_resp_entry = rd_resp_hit ? mem_rd_data : '0;

  vr_log_hdr_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .PTR_W   (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (tail[PTR_W-1:0]),
    .wr_data (append_entry),
    .rd_en   (rd_fire),
    .rd_addr (rd_addr),
    .rd_data (mem_rd_data)
  );

endmodule

// File: doc/vr_log_hdr_ring.md
Name: vr_log_hdr_ring

Overview:
- Parametrised circular log of VR log-entry headers: ordered append, op-number-indexed read, commit tracking, low-end reclamation (clean_up_to) and view-change tail truncation.
- Sits between the Prepare/StartView handlers and the log reader.
- Generalises the fixed-depth hdr_log_head/hdr_log_tail bookkeeping into a reusable block with depth/width parameters.

Parameters:
DEPTH, 2048, entry slots; power of two, >=4
ENTRY_W, LOG_ENTRY_HDR_W, stored header width
OP_W, 64, op-number width (INT_W)
PTR_W, $clog2(DEPTH), slot index width; head/tail carry PTR_W+1 bits (wrap bit)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
append_val  in  1  append request
append_op  in  OP_W  op number of entry
append_entry  in  ENTRY_W  header to store
append_rdy  out  1  append accepted when val&rdy
clean_val  in  1  reclaim request
clean_up_to  in  OP_W  free all entries with op < clean_up_to
trunc_val  in  1  view-change truncate request
trunc_op  in  OP_W  drop all entries with op > trunc_op
commit_val  in  1  commit advance
commit_op  in  OP_W  new last_commit candidate
rd_req_val  in  1  read request
rd_req_op  in  OP_W  op to read
rd_req_rdy  out  1  read accepted
rd_resp_val  out  1  response valid
rd_resp_hit  out  1  op present in log
rd_resp_committed  out  1  op <= last_commit
rd_resp_entry  out  ENTRY_W  stored header (zero on miss)
rd_resp_rdy  in  1  consumer ready
first_op, last_op, last_commit  out  OP_W  log bounds / commit point
head, tail  out  PTR_W+1  ring pointers
empty, full  out  1  status
err_seq  out  1  one-cycle pulse: rejected request

Behaviour:
- Reset, async, active-high: head=tail=0; first_op=last_op=last_commit=0; empty=1; full=0; rd_resp_val=0; err_seq=0; append_rdy=1 once rst deasserts.
- Occupancy: count = tail-head (PTR_W+1 arithmetic). empty: head==tail. full: indices equal and wrap bits differ.
- Slot for op = (head + (op-first_op)) mod DEPTH, low PTR_W bits.
- Append (append_rdy = !full):
  - Empty log: any op accepted; first_op=last_op=op.
  - Non-empty log: requires op == last_op+1, else dropped with err_seq pulse.
  - Write slot[tail], tail++, last_op=op.
- Clean (single cycle):
  - n = min(clean_up_to-first_op, count, committed entries); no-op if clean_up_to <= first_op.
  - head += n; first_op += n.
  - Never frees uncommitted entries.
- Truncate:
  - trunc_op < last_commit: rejected, err_seq.
  - trunc_op >= last_op: no-op.
  - Otherwise tail -= (last_op-trunc_op), last_op=trunc_op.
  - trunc_op < first_op: empties the log (tail=head).
- Commit: last_commit = min(commit_op, last_op) if greater than current; never decreases. Evaluated after same-cycle append/trunc.
- Priority per cycle: trunc > clean > append. Append is stalled (append_rdy=0) in any cycle trunc_val or clean_val is high. Commit and read proceed in parallel.
- Read:
  - rd_req_rdy = !rd_resp_val | rd_resp_rdy.
  - Lookup uses pre-update pointers of the accept cycle.
  - Response registered exactly 1 cycle after accept, held stable while rd_resp_val & !rd_resp_rdy.
  - hit = first_op <= op <= last_op and !empty.
  - Full throughput: one read per cycle.
- Wrap: pointers and slot index wrap naturally mod 2*DEPTH / DEPTH; op arithmetic is modular OP_W.
- Reset mid-operation: all state cleared; pending response discarded; RAM contents don't-care.

Optional Feature:
- Macro BEEHIVE_VR_LOG_AUTO_EVICT_EN.
- Defined: when full and oldest entry committed (first_op <= last_commit), append_rdy=1. An accepted append evicts the head entry in the same cycle (head++, first_op++).
- Undefined: append_rdy = !full strictly.

Decomposition:
- beehive_vr_pkg gains:
  - LOG_HDR_DEPTH default reuse
  - typedef vr_log_ring_status (first_op, last_op, last_commit, head, tail, empty, full)
  - enum vr_log_err {SEQ_GAP, TRUNC_COMMITTED}
- Sub-module vr_log_hdr_mem: 1R1W synchronous RAM, DEPTH x ENTRY_W, registered read, write-before-read not required (read/write same slot cannot both hit).

Test Plan:
- Reset, then append ops 10,11,12 -> first_op=10, last_op=12, tail=3. Read op 11 -> next cycle hit=1, entry matches.
- Append op 14 after 12 -> dropped, err_seq pulse, last_op=12. Read op 13 -> hit=0, entry=0.
- DEPTH=4: append 4 entries -> full=1, append_rdy=0. commit_op=5, clean_up_to=2 -> head advances 2. Two further appends wrap tail; reads of wrapped ops hit.
- last_commit=11, last_op=15: trunc_op=13 -> last_op=13, tail-=2. trunc_op=10 -> err_seq, unchanged.
- rd_resp_rdy held low 3 cycles with back-to-back requests -> response stable, rd_req_rdy=0, no loss. Release -> one response per cycle.
- With BEEHIVE_VR_LOG_AUTO_EVICT_EN, full log, last_commit>=first_op -> append accepted, first_op+1. Without it -> append stalls.
